// File: rtl/cnn_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_conv_scheduler
//  Purpose  : Sequences one convolution pass: loads the kernels into feature
//             memory, issues every valid window position to the conv datapath
//             over valid/ready, counts returned results and pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_conv_scheduler #(
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 12,
  parameter int NUM_FEATURES = 1,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  localparam int KW = KERNEL_SIZE * KERNEL_SIZE,
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst_cnn,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] wt_data,
  input  logic          wt_valid,
  output logic          wt_ready,
  output logic          wt_wr_en,
  output logic [FW-1:0] wt_addr,
  output logic [KW-1:0] wt_wdata,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [FW-1:0] win_feat,
  output logic          win_last,
  input  logic          res_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int OUT_H = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_W = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1;
  localparam int TOTAL = OUT_H * OUT_W * NUM_FEATURES;
  localparam int CNTW  = $clog2(TOTAL + 1);

  localparam logic [CNTW-1:0] TOTAL_C  = CNTW'(TOTAL);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(TOTAL - 1);
  localparam logic [FW-1:0]   FEAT_MAX = FW'(NUM_FEATURES - 1);
  localparam logic [CW-1:0]   COL_MAX  = CW'((OUT_W - 1) * STRIDE);
  localparam logic [CW-1:0]   COL_STEP = CW'(STRIDE);
  localparam logic [RW-1:0]   ROW_STEP = RW'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_CONV     = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   k;            // next kernel slot to load
  logic [CNTW-1:0] win_cnt;      // descriptors accepted by the datapath
  logic [CNTW-1:0] res_cnt;      // results returned so far
  logic [CNTW-1:0] res_cnt_nxt;
  logic            wt_acc;
  logic            win_acc;
  logic            res_ok;
  logic            res_bad;
  logic            clear;

  // State register
  always_ff @(posedge clk) begin
    if (rst_cnn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state, handshake qualifiers and state-decoded outputs.
  // Abort suppresses every handshake in its cycle, so acceptances are gated.
  always_comb begin
    wt_ready    = (state == S_LOAD_W);
    win_valid   = (state == S_CONV);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    win_last    = win_valid && (win_cnt == LAST_IDX);
    wt_acc      = wt_ready && wt_valid && !abort;
    win_acc     = win_valid && win_ready && !abort;
    // A result is legal only while a pass is live and something is outstanding;
    // counting against the pre-handshake total keeps a result that coincides
    // with the final descriptor handshake correctly accounted.
    res_ok      = res_valid && (state inside {S_LOAD_W, S_CONV, S_WAIT_RES})
                  && (res_cnt < win_cnt);
    res_bad     = res_valid && !res_ok;
    res_cnt_nxt = res_cnt + CNTW'(res_ok);
    clear       = (state == S_IDLE) && start;
    state_nxt   = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD_W;
      S_LOAD_W:   if (wt_acc && (k == FEAT_MAX)) state_nxt = S_CONV;
      S_CONV:     if (win_acc && win_last)
                    state_nxt = (res_cnt_nxt == TOTAL_C) ? S_DONE : S_WAIT_RES;
      S_WAIT_RES: if (res_cnt_nxt == TOTAL_C) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Weight write port, window descriptor walk, result counting and sticky error
  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      wt_wr_en <= 1'b0;
      wt_addr  <= '0;
      wt_wdata <= '0;
      k        <= '0;
      win_row  <= '0;
      win_col  <= '0;
      win_feat <= '0;
      win_cnt  <= '0;
      res_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      // Kernel captured on acceptance is written one cycle later.
      wt_wr_en <= wt_acc;
      if (wt_acc) begin
        wt_addr  <= k;
        wt_wdata <= wt_data;
        k        <= k + FW'(1);
      end
      if (clear) begin
        k        <= '0;
        win_row  <= '0;
        win_col  <= '0;
        win_feat <= '0;
        win_cnt  <= '0;
        res_cnt  <= '0;
        err      <= 1'b0;
      end else begin
        res_cnt <= res_cnt_nxt;
        if (res_bad) err <= 1'b1;
        if (win_acc) begin
          win_cnt <= win_cnt + CNTW'(1);
          // Feature index runs fastest, then column, then row.
          if (win_feat == FEAT_MAX) begin
            win_feat <= '0;
            if (win_col == COL_MAX) begin
              win_col <= '0;
              win_row <= win_row + ROW_STEP;
            end else begin
              win_col <= win_col + COL_STEP;
            end
          end else begin
            win_feat <= win_feat + FW'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
